// File: rtl/bus_arbiter_pkg.sv
// Shared definitions for the two-master bus arbiter: state encodings and
// master index constants.
package bus_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_OWN0 = 2'b01,
    ST_OWN1 = 2'b10
  } state_t;

  localparam logic M0 = 1'b0;
  localparam logic M1 = 1'b1;

  // Owned state corresponding to a master index.
  function automatic state_t own_state(input logic m);
    return m ? ST_OWN1 : ST_OWN0;
  endfunction

endpackage

// File: rtl/bus_arbiter_hold_cnt.sv
// Hold counter for the bus arbiter: counts owned cycles under contention,
// saturates at all-ones and flags the last cycle before a forced handover.
module arb_hold_cnt #(
  parameter int HOLD_MAX = 8,
  parameter int HOLD_W   = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam logic [HOLD_W-1:0] CNT_SAT = '1;
  localparam logic [HOLD_W-1:0] CNT_TC  = (HOLD_MAX == 0) ? '0 : HOLD_W'(HOLD_MAX - 1);

  logic [HOLD_W-1:0] cnt;

  // Clear has priority; counting stops at the saturation value.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && (cnt != CNT_SAT)) begin
      cnt <= cnt + HOLD_W'(1);
    end
  end

  // HOLD_MAX of zero disables preemption entirely.
  assign tc = (HOLD_MAX != 0) && (cnt == CNT_TC);

endmodule

// File: rtl/bus_arbiter.sv
// Two-master round-robin bus arbiter. Grants ownership to m0 or m1, drives the
// bus mux select, and bounds a contended ownership burst with a hold counter.
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int HOLD_MAX = 8,
  parameter int HOLD_W   = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic m0_req,
  input  logic m1_req,
  output logic m0_grant,
  output logic m1_grant,
  output logic msel,
  output logic bus_busy
);

  state_t state;
  state_t state_nxt;
  logic   last_owner;
  logic   other_req;
  logic   hold_tc;
  logic   hold_clr;
  logic   hold_en;

  // Request of the master currently waiting behind the owner.
  always_comb begin
    other_req = 1'b0;
    case (state)
      ST_OWN0: other_req = m1_req;
      ST_OWN1: other_req = m0_req;
      default: other_req = 1'b0;
    endcase
  end

  // Next-state arbitration: round-robin on contention from IDLE, direct
  // handover when the owner releases, forced handover when the hold expires.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (m0_req && m1_req)  state_nxt = own_state(~last_owner);
        else if (m0_req)       state_nxt = ST_OWN0;
        else if (m1_req)       state_nxt = ST_OWN1;
      end
      ST_OWN0: begin
        if (!m0_req)                state_nxt = m1_req ? ST_OWN1 : ST_IDLE;
        else if (m1_req && hold_tc) state_nxt = ST_OWN1;
      end
      ST_OWN1: begin
        if (!m1_req)                state_nxt = m0_req ? ST_OWN0 : ST_IDLE;
        else if (m0_req && hold_tc) state_nxt = ST_OWN0;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // The hold count only measures an unbroken stretch of contention within one
  // ownership; any state change or a quiet waiting master restarts it.
  always_comb begin
    hold_clr = (state_nxt != state) || (state == ST_IDLE) || !other_req;
    hold_en  = !hold_clr;
  end

  arb_hold_cnt #(
    .HOLD_MAX (HOLD_MAX),
    .HOLD_W   (HOLD_W)
  ) u_hold_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (hold_clr),
    .en      (hold_en),
    .tc      (hold_tc)
  );

  // State, round-robin memory and registered outputs; msel keeps its value
  // through IDLE so the bus mux never toggles without an owner.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      last_owner <= M1;
      m0_grant   <= 1'b0;
      m1_grant   <= 1'b0;
      msel       <= M0;
      bus_busy   <= 1'b0;
    end else begin
      state    <= state_nxt;
      m0_grant <= (state_nxt == ST_OWN0);
      m1_grant <= (state_nxt == ST_OWN1);
      bus_busy <= (state_nxt != ST_IDLE);
      if (state_nxt == ST_OWN0) begin
        msel <= M0;
      end else if (state_nxt == ST_OWN1) begin
        msel <= M1;
      end
      if ((state_nxt != state) && (state_nxt != ST_IDLE)) begin
        last_owner <= (state_nxt == ST_OWN1) ? M1 : M0;
      end
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter. Instance 0 uses HOLD_MAX=8, instance 1
// uses HOLD_MAX=0 (no preemption); both are compared against a behavioural model.
module tb_bus_arbiter;

  localparam int HOLD_W = 4;

  logic clk = 1'b0;
  logic reset_n;
  logic req0 [2];
  logic req1 [2];
  logic g0   [2];
  logic g1   [2];
  logic sel  [2];
  logic busy [2];

  int owner   [2];
  int last    [2];
  int waited  [2];
  logic msel_m [2];

  int n_total = 0;
  int n_pass  = 0;

  always #5 clk = ~clk;

  bus_arbiter #(.HOLD_MAX(8), .HOLD_W(HOLD_W)) dut (
    .clk(clk), .reset_n(reset_n), .m0_req(req0[0]), .m1_req(req1[0]),
    .m0_grant(g0[0]), .m1_grant(g1[0]), .msel(sel[0]), .bus_busy(busy[0])
  );

  bus_arbiter #(.HOLD_MAX(0), .HOLD_W(HOLD_W)) dut_np (
    .clk(clk), .reset_n(reset_n), .m0_req(req0[1]), .m1_req(req1[1]),
    .m0_grant(g0[1]), .m1_grant(g1[1]), .msel(sel[1]), .bus_busy(busy[1])
  );

  function automatic int hold_max(input int k);
    return (k == 0) ? 8 : 0;
  endfunction

  // Behavioural model: owner -1 = none, 0 = m0, 1 = m1.
  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      owner[k]  = -1;
      last[k]   = 1;
      waited[k] = 0;
      msel_m[k] = 1'b0;
    end
  endtask

  task automatic model_step(input int k, input logic r0, input logic r1);
    logic r [2];
    int o;
    int nw;
    r[0] = r0;
    r[1] = r1;
    o = owner[k];
    if (o < 0) begin
      if (r0 && r1)  nw = 1 - last[k];
      else if (r0)   nw = 0;
      else if (r1)   nw = 1;
      else           nw = -1;
    end else if (!r[o]) begin
      nw = r[1-o] ? 1 - o : -1;
    end else if (r[1-o] && hold_max(k) != 0 && waited[k] == hold_max(k) - 1) begin
      nw = 1 - o;
    end else begin
      nw = o;
    end
    if (nw >= 0 && nw == o && r[1-nw]) begin
      if (waited[k] < 2**HOLD_W - 1) waited[k] = waited[k] + 1;
    end else begin
      waited[k] = 0;
    end
    if (nw >= 0) begin
      if (nw != o) last[k] = nw;
      msel_m[k] = (nw == 1);
    end
    owner[k] = nw;
  endtask

  // Expected {m0_grant, m1_grant, msel, bus_busy}.
  function automatic logic [3:0] expv(input int k);
    return {owner[k] == 0, owner[k] == 1, msel_m[k], owner[k] >= 0};
  endfunction

  function automatic logic [3:0] obsv(input int k);
    return {g0[k], g1[k], sel[k], busy[k]};
  endfunction

  task automatic tick();
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      if (!reset_n) model_reset();
      else          model_step(k, req0[k], req1[k]);
    end
    #1;
  endtask

  task automatic set_req(input logic a, input logic b);
    req0[0] = a; req0[1] = a;
    req1[0] = b; req1[1] = b;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    set_req(1'b0, 1'b0);
    model_reset();
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    set_req(1'b0, 1'b0);
    model_reset();
    #1;
    for (int k = 0; k < 2; k++) begin
      n_total++;
      if (obsv(k) !== 4'b0000) $display("FAIL reset_async dut%0d got %b want 0000", k, obsv(k));
      else n_pass++;
    end
    tick();
    tick();
    for (int k = 0; k < 2; k++) begin
      n_total++;
      if (obsv(k) !== 4'b0000) $display("FAIL reset_clocked dut%0d got %b want 0000", k, obsv(k));
      else n_pass++;
    end
    reset_n = 1'b1;
  endtask

  task automatic test_single_grant();
    do_reset();
    set_req(1'b1, 1'b0);
    #1;
    n_total++;
    if (g0[0] !== 1'b0) $display("FAIL grant_latency got m0_grant=%b want 0 before edge", g0[0]);
    else n_pass++;
    tick();
    for (int k = 0; k < 2; k++) begin
      n_total++;
      if (obsv(k) !== 4'b1001) $display("FAIL single_m0 dut%0d got %b want 1001", k, obsv(k));
      else n_pass++;
    end
    tick();
    for (int k = 0; k < 2; k++) begin
      n_total++;
      if (obsv(k) !== 4'b1001) $display("FAIL single_m0_hold dut%0d got %b want 1001", k, obsv(k));
      else n_pass++;
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] want [3];
    want[0] = 4'b1001;
    want[1] = 4'b0000;
    want[2] = 4'b0111;
    do_reset();
    for (int s = 0; s < 3; s++) begin
      if (s == 1) set_req(1'b0, 1'b0);
      else        set_req(1'b1, 1'b1);
      tick();
      for (int k = 0; k < 2; k++) begin
        n_total++;
        if (obsv(k) !== want[s] || obsv(k) !== expv(k))
          $display("FAIL round_robin dut%0d step%0d got %b want %b", k, s, obsv(k), want[s]);
        else n_pass++;
      end
    end
  endtask

  task automatic test_preempt();
    logic [3:0] want;
    do_reset();
    set_req(1'b1, 1'b0);
    tick();
    set_req(1'b1, 1'b1);
    for (int i = 1; i <= 16; i++) begin
      tick();
      for (int k = 0; k < 2; k++) begin
        if (k == 1)      want = 4'b1001;
        else if (i < 8)  want = 4'b1001;
        else if (i < 16) want = 4'b0111;
        else             want = 4'b1001;
        n_total++;
        if (obsv(k) !== want || (g0[k] & g1[k]) !== 1'b0)
          $display("FAIL preempt dut%0d cyc%0d got %b want %b", k, i, obsv(k), want);
        else n_pass++;
      end
    end
  endtask

  task automatic test_handover();
    do_reset();
    set_req(1'b1, 1'b0);
    tick();
    set_req(1'b1, 1'b1);
    tick();
    set_req(1'b0, 1'b1);
    tick();
    for (int k = 0; k < 2; k++) begin
      n_total++;
      if (obsv(k) !== 4'b0111) $display("FAIL handover dut%0d got %b want 0111", k, obsv(k));
      else n_pass++;
    end
    set_req(1'b0, 1'b0);
    tick();
    for (int k = 0; k < 2; k++) begin
      n_total++;
      if (obsv(k) !== 4'b0010) $display("FAIL idle_msel_hold dut%0d got %b want 0010", k, obsv(k));
      else n_pass++;
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    set_req(1'b0, 1'b1);
    tick();
    tick();
    for (int k = 0; k < 2; k++) begin
      n_total++;
      if (obsv(k) !== 4'b0111) $display("FAIL m1_owns dut%0d got %b want 0111", k, obsv(k));
      else n_pass++;
    end
    #2;
    reset_n = 1'b0;
    model_reset();
    #1;
    for (int k = 0; k < 2; k++) begin
      n_total++;
      if (obsv(k) !== 4'b0000) $display("FAIL midburst_reset dut%0d got %b want 0000", k, obsv(k));
      else n_pass++;
    end
    #2;
    reset_n = 1'b1;
    tick();
    for (int k = 0; k < 2; k++) begin
      n_total++;
      if (obsv(k) !== 4'b0111) $display("FAIL rearbitrate dut%0d got %b want 0111", k, obsv(k));
      else n_pass++;
    end
  endtask

  task automatic test_no_preempt();
    do_reset();
    set_req(1'b1, 1'b1);
    for (int i = 0; i < 100; i++) begin
      tick();
      n_total++;
      if (obsv(1) !== 4'b1001 || busy[1] !== (g0[1] | g1[1]))
        $display("FAIL no_preempt cyc%0d got %b want 1001", i, obsv(1));
      else n_pass++;
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(3) == 0) begin
        req0[0] = ~req0[0];
        req0[1] = req0[0];
      end
      if ($urandom_range(3) == 0) begin
        req1[0] = ~req1[0];
        req1[1] = req1[0];
      end
      if ($urandom_range(63) == 0) reset_n = 1'b0;
      tick();
      reset_n = 1'b1;
      for (int k = 0; k < 2; k++) begin
        n_total++;
        if (obsv(k) !== expv(k) || (g0[k] & g1[k]) !== 1'b0 || busy[k] !== (g0[k] | g1[k]))
          $display("FAIL random dut%0d cyc%0d got %b want %b", k, i, obsv(k), expv(k));
        else n_pass++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_grant();
    test_round_robin();
    test_preempt();
    test_handover();
    test_async_reset();
    test_no_preempt();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
